rob_multi_commit: RTL and testbench
===================================

# rob_multi_commit

Parametrised reorder buffer for the Tomasulo core with a configurable depth, N broadcast (CDB) ports, up to COMMIT_W in-order commits per cycle and selective flush on mispredict. Only entries younger than the mispredicting instruction are discarded. It sits between the decoder/issue stage, the execution units (ALU, LSB) and the register file / load-store buffer commit path. A circular queue of tagged entries retires results in program order.

## Interface
- DEPTH, 16: entries; power of two, ≥4.
- TAG_W, 5: tag width; ≥ clog2(DEPTH)+1. Tags 1..DEPTH, tag 0 = NULL.
- CDB_PORTS, 2: number of result broadcast ports.
- COMMIT_W, 2: maximum commits per cycle, 1..4.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- issue_valid  in  1  allocate one entry this cycle.
- issue_ready  out  1  comb; count < DEPTH and no flush registered this cycle.
- issue_tag  out  TAG_W  comb; tag the next allocation receives; NULL when full.
- issue_inst  in  32  instruction word; opcode in [6:0].
- issue_rd  in  5  destination register.
- issue_predict_pc  in  32  predicted next PC.
- q_tag_a, q_tag_b  in  TAG_W  operand tag queries.
- q_ready_a, q_ready_b  out  1  comb; entry result valid.
- q_data_a, q_data_b  out  32  comb; entry result.
- cdb_valid  in  CDB_PORTS  per-port broadcast strobe.
- cdb_tag  in  CDB_PORTS*TAG_W  flat; port p at [p*TAG_W +: TAG_W].
- cdb_data  in  CDB_PORTS*32  flat results.
- cdb_new_pc  in  CDB_PORTS*32  resolved next PC; used only for JALR/BRANCH/AUIPC.
- commit_valid  out  COMMIT_W  registered; lane i valid.
- commit_tag  out  COMMIT_W*TAG_W  registered.
- commit_data  out  COMMIT_W*32  registered.
- commit_rd  out  COMMIT_W*5  registered.
- rollback_out  out  1  registered one-cycle pulse.
- rollback_pc  out  32  registered; valid with rollback_out.
- rollback_tag  out  TAG_W  registered; youngest surviving tag. Units drop all younger tags.

## Operation
- State: head, tail and count registers, plus per-entry ready/inst/data/rd/predict_pc.
- Entry age = (tag − 1 − head) mod DEPTH. Empty when count==0; full when count==DEPTH.
- Issue: when issue_valid && issue_ready, write the entry at issue_tag with ready=0 and data=0, then advance tail modulo DEPTH. Issue while full or flushing is ignored.
- CDB: for each valid port, write data and set ready.
  - Ports target distinct tags; same-tag collisions are undefined.
  - Writes to NULL, unallocated or same-cycle-flushed tags are ignored.
- Mispredict: a broadcast whose entry opcode is JALR, BRANCH or AUIPC and whose cdb_new_pc ≠ predict_pc.
  - If several ports mispredict in one cycle, the oldest wins.
  - The entry itself is kept and marked ready.
  - tail becomes that entry and count is recomputed; younger entries are invalidated.
  - Next cycle: rollback_out=1, rollback_pc=cdb_new_pc, rollback_tag=that tag.
- Commit: scan from head for up to COMMIT_W consecutive entries and stop at the first one that cannot commit.
  - An entry commits if ready, or if its opcode is STORE (stores commit at head without a result).
  - At most one store per cycle, and only in lane 0.
  - Committed entries clear ready. head and count advance by the number committed.
- Same-cycle events are applied in priority order: commit, then CDB, then flush, then issue.
  - Commit of entries older than or equal to the mispredicting entry proceeds in the same cycle.
  - A same-cycle CDB write is not seen by commit until the next cycle.
- count update per cycle = issued − committed − flushed. Wrap-around uses modulo DEPTH on all pointers.
- Reset: head=tail=count=0, all entries cleared, all outputs 0.
  - Reset mid-operation discards everything; no pending rollback or commit pulse survives.

## Timing
- Issue → entry visible to queries: next cycle.
- CDB at edge N sets ready. Earliest commit output is registered at edge N+1, so it is visible one cycle after the broadcast.
- A mispredict seen at edge N gives rollback_out high for exactly the cycle after edge N. issue_ready is low during that cycle.
- commit_valid and rollback_out are single-cycle pulses, not held.
- Query outputs are combinational, with zero latency.

## Configuration
- ROB_CDB_BYPASS_EN defined: each q_* output forwards a matching same-cycle valid CDB port (q_ready=1, q_data=cdb_data). This saves one issue-to-dispatch cycle.
- ROB_CDB_BYPASS_EN undefined: q_* outputs reflect registered entry state only.

## Test plan
- Reset, then issue 16 ADDs (DEPTH=16) → issue_ready=0 after the 16th and issue_tag=0. Broadcast tags 1,2 on both ports → next cycle commit_valid=2'b11 with tags 1,2 and issue_ready=1.
- Issue SW, ADD, SW with none ready → cycle 1 commits the first SW alone in lane 0. After the ADD broadcasts, the next cycle commits ADD in lane 0 only; the second SW commits the following cycle in lane 0.
- Issue 6 entries; BRANCH at tag 3 resolves with cdb_new_pc=0x100 against predict 0x8 → rollback_out=1, rollback_pc=0x100, rollback_tag=3. Next issue_tag=4; tags 4–6 are never committed.
- Two ports mispredict tags 5 and 2 in the same cycle → rollback_tag=2 with tag 2's new PC.
- Wrap: fill and drain 40 entries → commit order is strictly ascending modulo 16, wrapping 16→1.
- With ROB_CDB_BYPASS_EN: query tag 7 while port 1 broadcasts tag 7 with 0xDEAD → q_ready_a=1 and q_data_a=0xDEAD in the same cycle. Without the macro, q_ready_a=0 in that cycle.

Source files
------------

// File: rtl/rob_multi_commit.sv
// rob_multi_commit: reorder buffer for the Tomasulo core.
// Circular queue of tagged entries (tag = index + 1, tag 0 = NULL), CDB_PORTS
// result write ports, up to COMMIT_W in-order commits per cycle, and selective
// flush of entries younger than a mispredicting JALR/BRANCH/AUIPC.
// Optional feature macro: ROB_CDB_BYPASS_EN forwards same-cycle CDB results
// to the operand query ports (q_ready_*/q_data_*).
`timescale 1ns/1ps
module rob_multi_commit #(
    parameter int DEPTH     = 16,
    parameter int TAG_W     = 5,
    parameter int CDB_PORTS = 2,
    parameter int COMMIT_W  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    output logic [TAG_W-1:0]           issue_tag,
    input  logic [31:0]                issue_inst,
    input  logic [4:0]                 issue_rd,
    input  logic [31:0]                issue_predict_pc,
    input  logic [TAG_W-1:0]           q_tag_a,
    input  logic [TAG_W-1:0]           q_tag_b,
    output logic                       q_ready_a,
    output logic                       q_ready_b,
    output logic [31:0]                q_data_a,
    output logic [31:0]                q_data_b,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*32-1:0]    cdb_data,
    input  logic [CDB_PORTS*32-1:0]    cdb_new_pc,
    output logic [COMMIT_W-1:0]        commit_valid,
    output logic [COMMIT_W*TAG_W-1:0]  commit_tag,
    output logic [COMMIT_W*32-1:0]     commit_data,
    output logic [COMMIT_W*5-1:0]      commit_rd,
    output logic                       rollback_out,
    output logic [31:0]                rollback_pc,
    output logic [TAG_W-1:0]           rollback_tag
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          ready_r [DEPTH];
    logic [31:0]   inst_r  [DEPTH];
    logic [31:0]   data_r  [DEPTH];
    logic [31:0]   ppc_r   [DEPTH];
    logic [4:0]    rd_r    [DEPTH];

    logic [COMMIT_W-1:0]  lane_v_s;
    logic [PW-1:0]        lane_idx_s [COMMIT_W];
    logic [CW-1:0]        n_commit_s;
    logic                 scan_go_s;
    logic [PW-1:0]        cdb_idx_s [CDB_PORTS];
    logic [PW-1:0]        cdb_age_s [CDB_PORTS];
    logic [CDB_PORTS-1:0] cdb_ok_s;
    logic [CDB_PORTS-1:0] cdb_wr_s;
    logic                 mis_any_s;
    logic [PW-1:0]        mis_age_s;
    logic [PW-1:0]        mis_idx_s;
    logic [31:0]          mis_pc_s;
    logic [TAG_W-1:0]     mis_tag_s;
    logic [CW-1:0]        flush_count_s;
    logic                 issue_acc_s;

    function automatic logic [PW-1:0] tag_idx(input logic [TAG_W-1:0] tag);
        logic [TAG_W-1:0] t;
        t = tag - TAG_W'(1);
        return t[PW-1:0];
    endfunction

    function automatic logic tag_ok(input logic [TAG_W-1:0] tag);
        return (tag != '0) && (tag <= TAG_W'(DEPTH));
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OP_JALR) || (op == OP_BRANCH) || (op == OP_AUIPC);
    endfunction

    // Operand lookup: registered entry state, optionally overridden by a live CDB port.
    function automatic logic [32:0] query(input logic [TAG_W-1:0] tag);
        logic [PW-1:0] idx;
        logic [PW-1:0] age;
        logic [32:0]   res;
        idx = tag_idx(tag);
        age = idx - head_r;
        if (tag_ok(tag) && ({1'b0, age} < count_r)) res = {ready_r[idx], data_r[idx]};
        else res = 33'd0;
`ifdef ROB_CDB_BYPASS_EN
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_valid[p] && tag_ok(tag) && (cdb_tag[p*TAG_W +: TAG_W] == tag))
                res = {1'b1, cdb_data[p*32 +: 32]};
            else res = res;
        end
`endif
        return res;
    endfunction

    // Allocation handshake: free slot and no rollback pulse in flight.
    always_comb begin
        issue_ready = (count_r < CW'(DEPTH)) && !rollback_out;
        if (count_r < CW'(DEPTH)) issue_tag = TAG_W'(tail_r) + TAG_W'(1);
        else issue_tag = '0;
    end

    // Operand query ports.
    always_comb begin
        {q_ready_a, q_data_a} = query(q_tag_a);
        {q_ready_b, q_data_b} = query(q_tag_b);
    end

    // In-order commit scan from head; a store may only retire alone in lane 0.
    always_comb begin
        lane_v_s   = '0;
        n_commit_s = '0;
        scan_go_s  = 1'b1;
        for (int i = 0; i < COMMIT_W; i++) begin
            lane_idx_s[i] = head_r + PW'(i);
            if (scan_go_s && (CW'(i) < count_r) &&
                ((inst_r[lane_idx_s[i]][6:0] == OP_STORE) ? (i == 0) : ready_r[lane_idx_s[i]])) begin
                lane_v_s[i] = 1'b1;
                n_commit_s  = n_commit_s + CW'(1);
            end else begin
                scan_go_s = 1'b0;
            end
        end
    end

    // CDB qualification and oldest-mispredict selection; younger writes are dropped.
    always_comb begin
        mis_any_s = 1'b0;
        mis_age_s = '0;
        mis_idx_s = '0;
        mis_pc_s  = '0;
        mis_tag_s = '0;
        cdb_ok_s  = '0;
        cdb_wr_s  = '0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            cdb_idx_s[p] = tag_idx(cdb_tag[p*TAG_W +: TAG_W]);
            cdb_age_s[p] = cdb_idx_s[p] - head_r;
            cdb_ok_s[p]  = cdb_valid[p] && tag_ok(cdb_tag[p*TAG_W +: TAG_W]) &&
                           ({1'b0, cdb_age_s[p]} < count_r) &&
                           ({1'b0, cdb_age_s[p]} >= n_commit_s);
            if (cdb_ok_s[p] && is_ctrl(inst_r[cdb_idx_s[p]][6:0]) &&
                (cdb_new_pc[p*32 +: 32] != ppc_r[cdb_idx_s[p]]) &&
                (!mis_any_s || (cdb_age_s[p] < mis_age_s))) begin
                mis_any_s = 1'b1;
                mis_age_s = cdb_age_s[p];
                mis_idx_s = cdb_idx_s[p];
                mis_pc_s  = cdb_new_pc[p*32 +: 32];
                mis_tag_s = cdb_tag[p*TAG_W +: TAG_W];
            end else begin
                mis_any_s = mis_any_s;
            end
        end
        for (int p = 0; p < CDB_PORTS; p++) begin
            cdb_wr_s[p] = cdb_ok_s[p] && (!mis_any_s || (cdb_age_s[p] <= mis_age_s));
        end
        flush_count_s = {1'b0, mis_age_s} + CW'(1) - n_commit_s;
        issue_acc_s   = issue_valid && issue_ready && !mis_any_s;
    end

    // State update in priority order commit, CDB, flush, issue; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r       <= '0;
            tail_r       <= '0;
            count_r      <= '0;
            commit_valid <= '0;
            commit_tag   <= '0;
            commit_data  <= '0;
            commit_rd    <= '0;
            rollback_out <= 1'b0;
            rollback_pc  <= 32'd0;
            rollback_tag <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                ready_r[e] <= 1'b0;
                inst_r[e]  <= 32'd0;
                data_r[e]  <= 32'd0;
                ppc_r[e]   <= 32'd0;
                rd_r[e]    <= 5'd0;
            end
        end else begin
            commit_valid <= lane_v_s;
            for (int i = 0; i < COMMIT_W; i++) begin
                commit_tag[i*TAG_W +: TAG_W] <= lane_v_s[i] ? (TAG_W'(lane_idx_s[i]) + TAG_W'(1)) : '0;
                commit_data[i*32 +: 32]      <= lane_v_s[i] ? data_r[lane_idx_s[i]] : 32'd0;
                commit_rd[i*5 +: 5]          <= lane_v_s[i] ? rd_r[lane_idx_s[i]] : 5'd0;
                if (lane_v_s[i]) ready_r[lane_idx_s[i]] <= 1'b0;
            end
            head_r <= head_r + PW'(n_commit_s);
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (cdb_wr_s[p]) begin
                    ready_r[cdb_idx_s[p]] <= 1'b1;
                    data_r[cdb_idx_s[p]]  <= cdb_data[p*32 +: 32];
                end
            end
            rollback_out <= mis_any_s;
            rollback_pc  <= mis_any_s ? mis_pc_s : 32'd0;
            rollback_tag <= mis_any_s ? mis_tag_s : '0;
            if (mis_any_s) begin
                tail_r  <= mis_idx_s + PW'(1);
                count_r <= flush_count_s;
                for (int e = 0; e < DEPTH; e++) begin
                    if ((PW'(e) - head_r) > mis_age_s) ready_r[e] <= 1'b0;
                end
            end else begin
                if (issue_acc_s) begin
                    ready_r[tail_r] <= 1'b0;
                    data_r[tail_r]  <= 32'd0;
                    inst_r[tail_r]  <= issue_inst;
                    ppc_r[tail_r]   <= issue_predict_pc;
                    rd_r[tail_r]    <= issue_rd;
                    tail_r          <= tail_r + PW'(1);
                end
                count_r <= count_r - n_commit_s + CW'(issue_acc_s);
            end
        end
    end
endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed testbench for rob_multi_commit (DEPTH=16, TAG_W=5, 2 CDB ports, 2 commit lanes).
`timescale 1ns/1ps
module tb_rob_multi_commit;
    localparam int TAG_W = 5;
    localparam int CP    = 2;
    localparam int CWD   = 2;
    localparam logic [31:0] I_ADD   = 32'h00000033;
    localparam logic [31:0] I_SW    = 32'h00000023;
    localparam logic [31:0] I_BR    = 32'h00000063;
    localparam logic [31:0] I_JALR  = 32'h00000067;
    localparam logic [31:0] I_AUIPC = 32'h00000017;
`ifdef ROB_CDB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic issue_valid, issue_ready;
    logic [TAG_W-1:0] issue_tag;
    logic [31:0] issue_inst, issue_predict_pc;
    logic [4:0] issue_rd;
    logic [TAG_W-1:0] q_tag_a, q_tag_b;
    logic q_ready_a, q_ready_b;
    logic [31:0] q_data_a, q_data_b;
    logic [CP-1:0] cdb_valid;
    logic [CP*TAG_W-1:0] cdb_tag;
    logic [CP*32-1:0] cdb_data, cdb_new_pc;
    logic [CWD-1:0] commit_valid;
    logic [CWD*TAG_W-1:0] commit_tag;
    logic [CWD*32-1:0] commit_data;
    logic [CWD*5-1:0] commit_rd;
    logic rollback_out;
    logic [31:0] rollback_pc;
    logic [TAG_W-1:0] rollback_tag;

    int tests_run = 0;
    int tests_failed = 0;

    rob_multi_commit #(.DEPTH(16), .TAG_W(TAG_W), .CDB_PORTS(CP), .COMMIT_W(CWD)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .issue_inst(issue_inst), .issue_rd(issue_rd), .issue_predict_pc(issue_predict_pc),
        .q_tag_a(q_tag_a), .q_tag_b(q_tag_b), .q_ready_a(q_ready_a), .q_ready_b(q_ready_b),
        .q_data_a(q_data_a), .q_data_b(q_data_b),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_new_pc(cdb_new_pc),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_data(commit_data),
        .commit_rd(commit_rd), .rollback_out(rollback_out), .rollback_pc(rollback_pc),
        .rollback_tag(rollback_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cdb();
        cdb_valid  = '0;
        cdb_tag    = '0;
        cdb_data   = '0;
        cdb_new_pc = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_inst = 32'd0;
        issue_rd = 5'd0;
        issue_predict_pc = 32'd0;
        q_tag_a = '0;
        q_tag_b = '0;
        clear_cdb();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [31:0] ppc);
        issue_valid = 1'b1;
        issue_inst = inst;
        issue_rd = 5'd3;
        issue_predict_pc = ppc;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic set_cdb(input int p, input logic [TAG_W-1:0] tag, input logic [31:0] d,
                           input logic [31:0] npc);
        cdb_valid[p] = 1'b1;
        cdb_tag[p*TAG_W +: TAG_W] = tag;
        cdb_data[p*32 +: 32] = d;
        cdb_new_pc[p*32 +: 32] = npc;
    endtask

    initial begin
        int next_tag;
        int seq;

        // Reset state
        do_reset();
        q_tag_a = 5'd1;
        #1;
        check("rst_commit_valid", 64'(commit_valid), 64'd0);
        check("rst_rollback", 64'(rollback_out), 64'd0);
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_issue_tag", 64'(issue_tag), 64'd1);
        check("rst_q_ready", 64'(q_ready_a), 64'd0);

        // Fill to full, then broadcast tags 1,2 on both ports
        for (int k = 0; k < 16; k++) begin
            check("fill_tag", 64'(issue_tag), 64'(k + 1));
            issue(I_ADD, 32'd0);
        end
        check("full_ready", 64'(issue_ready), 64'd0);
        check("full_tag", 64'(issue_tag), 64'd0);
        set_cdb(0, 5'd1, 32'h11, 32'd0);
        set_cdb(1, 5'd2, 32'h22, 32'd0);
        tick();
        clear_cdb();
        check("cdb_no_commit_yet", 64'(commit_valid), 64'd0);
        q_tag_a = 5'd1;
        #1;
        check("q_ready_t1", 64'(q_ready_a), 64'd1);
        check("q_data_t1", 64'(q_data_a), 64'h11);
        tick();
        check("dual_commit_valid", 64'(commit_valid), 64'b11);
        check("dual_commit_tag", 64'(commit_tag), 64'({5'd2, 5'd1}));
        check("dual_commit_data", 64'(commit_data), {32'h22, 32'h11});
        check("after_commit_ready", 64'(issue_ready), 64'd1);
        check("after_commit_tag", 64'(issue_tag), 64'd1);
        tick();
        check("commit_pulse", 64'(commit_valid), 64'd0);

        // Stores: SW, ADD, SW
        do_reset();
        issue(I_SW, 32'd0);
        issue(I_ADD, 32'd0);
        check("sw1_commit_valid", 64'(commit_valid), 64'b01);
        check("sw1_commit_tag", 64'(commit_tag[4:0]), 64'd1);
        issue(I_SW, 32'd0);
        check("add_blocks", 64'(commit_valid), 64'd0);
        set_cdb(0, 5'd2, 32'h55, 32'd0);
        tick();
        clear_cdb();
        check("add_cdb_wait", 64'(commit_valid), 64'd0);
        tick();
        check("add_commit_valid", 64'(commit_valid), 64'b01);
        check("add_commit_tag", 64'(commit_tag[4:0]), 64'd2);
        check("add_commit_data", 64'(commit_data[31:0]), 64'h55);
        tick();
        check("sw2_commit_valid", 64'(commit_valid), 64'b01);
        check("sw2_commit_tag", 64'(commit_tag[4:0]), 64'd3);
        tick();
        check("sw_drained", 64'(commit_valid), 64'd0);
        check("sw_next_tag", 64'(issue_tag), 64'd4);

        // Branch mispredict at tag 3
        do_reset();
        issue(I_ADD, 32'd0);
        issue(I_ADD, 32'd0);
        issue(I_BR, 32'h8);
        issue(I_ADD, 32'd0);
        issue(I_ADD, 32'd0);
        issue(I_ADD, 32'd0);
        set_cdb(0, 5'd3, 32'd0, 32'h100);
        tick();
        clear_cdb();
        check("rb_out", 64'(rollback_out), 64'd1);
        check("rb_pc", 64'(rollback_pc), 64'h100);
        check("rb_tag", 64'(rollback_tag), 64'd3);
        check("rb_issue_ready", 64'(issue_ready), 64'd0);
        check("rb_issue_tag", 64'(issue_tag), 64'd4);
        tick();
        check("rb_pulse", 64'(rollback_out), 64'd0);
        check("rb_ready_back", 64'(issue_ready), 64'd1);
        set_cdb(0, 5'd1, 32'hA1, 32'd0);
        set_cdb(1, 5'd2, 32'hA2, 32'd0);
        tick();
        clear_cdb();
        set_cdb(0, 5'd5, 32'h77, 32'd0);
        tick();
        clear_cdb();
        check("rb_commit_12", 64'(commit_valid), 64'b11);
        q_tag_a = 5'd5;
        #1;
        check("flushed_q_ready", 64'(q_ready_a), 64'd0);
        tick();
        check("rb_commit_3_valid", 64'(commit_valid), 64'b01);
        check("rb_commit_3_tag", 64'(commit_tag[4:0]), 64'd3);
        tick();
        check("rb_no_younger", 64'(commit_valid), 64'd0);
        check("rb_final_tag", 64'(issue_tag), 64'd4);

        // Two mispredicts in one cycle: oldest wins
        do_reset();
        issue(I_ADD, 32'd0);
        issue(I_BR, 32'h8);
        issue(I_ADD, 32'd0);
        issue(I_ADD, 32'd0);
        issue(I_JALR, 32'h8);
        issue(I_ADD, 32'd0);
        set_cdb(0, 5'd5, 32'h5, 32'h500);
        set_cdb(1, 5'd2, 32'h2, 32'h200);
        tick();
        clear_cdb();
        check("mm_out", 64'(rollback_out), 64'd1);
        check("mm_tag", 64'(rollback_tag), 64'd2);
        check("mm_pc", 64'(rollback_pc), 64'h200);
        tick();
        check("mm_issue_tag", 64'(issue_tag), 64'd3);
        issue(I_AUIPC, 32'h40);
        set_cdb(0, 5'd3, 32'h99, 32'h40);
        tick();
        clear_cdb();
        check("correct_pred_no_rb", 64'(rollback_out), 64'd0);
        q_tag_a = 5'd3;
        q_tag_b = 5'd5;
        #1;
        check("auipc_q_ready", 64'(q_ready_a), 64'd1);
        check("flushed_t5_q", 64'(q_ready_b), 64'd0);

        // Wrap: 40 entries issued and drained in a pipeline
        do_reset();
        next_tag = 1;
        seq = 0;
        for (int c = 0; c < 44; c++) begin
            issue_valid = (c < 40);
            issue_inst = I_ADD;
            if (c < 40) check("wrap_issue_tag", 64'(issue_tag), 64'((c % 16) + 1));
            clear_cdb();
            if (c >= 1 && c <= 40) set_cdb(0, 5'(((c - 1) % 16) + 1), 32'(c - 1), 32'd0);
            tick();
            issue_valid = 1'b0;
            clear_cdb();
            for (int l = 0; l < CWD; l++) begin
                if (commit_valid[l]) begin
                    check("wrap_commit_tag", 64'(commit_tag[l*TAG_W +: TAG_W]), 64'(next_tag));
                    check("wrap_commit_data", 64'(commit_data[l*32 +: 32]), 64'(seq));
                    next_tag = (next_tag == 16) ? 1 : next_tag + 1;
                    seq++;
                end
            end
        end
        check("wrap_total", 64'(seq), 64'd40);

        // Same-cycle query of a broadcasting tag
        do_reset();
        for (int k = 0; k < 8; k++) issue(I_ADD, 32'd0);
        set_cdb(1, 5'd7, 32'hDEAD, 32'd0);
        q_tag_a = 5'd7;
        q_tag_b = 5'd3;
        #1;
        check("byp_q_ready", 64'(q_ready_a), 64'(BYP));
        check("byp_q_data", 64'(q_data_a), BYP ? 64'hDEAD : 64'd0);
        check("byp_other_q", 64'(q_ready_b), 64'd0);
        tick();
        clear_cdb();
        check("post_cdb_q_ready", 64'(q_ready_a), 64'd1);
        check("post_cdb_q_data", 64'(q_data_a), 64'hDEAD);

        // Reset mid-operation drops a pending commit
        do_reset();
        issue(I_ADD, 32'd0);
        set_cdb(0, 5'd1, 32'h42, 32'd0);
        tick();
        clear_cdb();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q_tag_a = 5'd1;
        #1;
        check("midrst_commit", 64'(commit_valid), 64'd0);
        check("midrst_tag", 64'(issue_tag), 64'd1);
        check("midrst_q_ready", 64'(q_ready_a), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
